cs_encoder_acc: RTL

- Parametrised compressed-sensing measurement encoder: y = Phi·x, Phi in {+1,-1}^(M×N), frame of N signed samples.
- Phi bits supplied LANES per cycle by an external PRBS/LFSR; M accumulators held internally.
- Completed measurement vector drained as a valid/ready stream to measurement RAM/packetiser; accumulators cleared for the next frame.
- Sits between the threshold/quantiser stage (sample source) and the measurement RAM writer.

---
 rtl/cs_encoder_acc_pkg.sv | 28 ++
 rtl/cs_encoder_acc_if.sv | 30 +++
 rtl/cs_encoder_acc_acc_bank.sv | 21 ++
 rtl/cs_encoder_acc.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cs_encoder_acc_pkg.sv
// Shared types, sizing helpers and default parameters for the CS measurement encoder.
package cs_pkg;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   localparam int unsigned N_DEF     = 256;
   localparam int unsigned M_DEF     = 512;
   localparam int unsigned LANES_DEF = 64;
   localparam int unsigned DW_DEF    = 12;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   // Accumulator width wide enough that N full-scale samples cannot overflow.
   function automatic int unsigned acc_w(input int unsigned dw, input int unsigned n);
      return dw + clog2(n) + 1;
   endfunction

endpackage

// File: rtl/cs_encoder_acc_if.sv
// Sample, Phi and measurement stream signals of the CS encoder.
interface cs_encoder_acc_if #(
   parameter int unsigned DW    = 12,
   parameter int unsigned ACC_W = 21,
   parameter int unsigned LANES = 64,
   parameter int unsigned IW    = 9
);
   logic signed [DW-1:0]    x_data;
   logic                    x_valid;
   logic                    x_ready;
   logic [LANES-1:0]        phi_in;
   logic                    phi_req;
   logic signed [ACC_W-1:0] y_data;
   logic [IW-1:0]           y_idx;
   logic                    y_valid;
   logic                    y_ready;
   logic                    y_last;
   logic                    busy;
   logic                    done;

   modport slave (
      input  x_data, x_valid, phi_in, y_ready,
      output x_ready, phi_req, y_data, y_idx, y_valid, y_last, busy, done
   );

   modport master (
      output x_data, x_valid, phi_in, y_ready,
      input  x_ready, phi_req, y_data, y_idx, y_valid, y_last, busy, done
   );
endinterface

// File: rtl/cs_encoder_acc_acc_bank.sv
// LANES parallel +/- x units: lane adds x when its Phi bit is 1, subtracts otherwise.
module cs_acc_bank #(
   parameter int unsigned LANES = 64,
   parameter int unsigned DW    = 12,
   parameter int unsigned ACC_W = 21
) (
   input  logic signed [DW-1:0]    x_reg,
   input  logic [LANES-1:0]        phi,
   input  logic signed [ACC_W-1:0] acc_in  [LANES],
   output logic signed [ACC_W-1:0] acc_out [LANES]
);
   logic signed [ACC_W-1:0] x_ext;

   // Sign-extend the sample, then add or subtract per lane (wraps, no saturation).
   always_comb begin
      x_ext = {{(ACC_W-DW){x_reg[DW-1]}}, x_reg};
      for (int l = 0; l < int'(LANES); l++) begin
         acc_out[l] = phi[l] ? (acc_in[l] + x_ext) : (acc_in[l] - x_ext);
      end
   end
endmodule

// File: rtl/cs_encoder_acc.sv
// Compressed-sensing encoder: y = Phi*x over a frame, then drains y[] as a stream.
module cs_encoder_acc
   import cs_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned M     = M_DEF,
   parameter int unsigned LANES = LANES_DEF,
   parameter int unsigned DW    = DW_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic abort,
   cs_encoder_acc_if.slave bus
);
   localparam int unsigned ACC_W = acc_w(DW, N);
   localparam int unsigned P     = M / LANES;
   localparam int unsigned CW    = (N > 1) ? clog2(N) : 1;
   localparam int unsigned PW    = (P > 1) ? clog2(P) : 1;
   localparam int unsigned IW    = (M > 1) ? clog2(M) : 1;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [PW-1:0]           pass_q, pass_d;
   logic [IW-1:0]           rd_q, rd_d;
   logic signed [DW-1:0]    x_reg_q;
   logic signed [ACC_W-1:0] y_q [M];
   logic signed [ACC_W-1:0] acc_rd [LANES];
   logic signed [ACC_W-1:0] acc_wr [LANES];

   logic                    x_load, acc_we, y_clr;
   logic                    x_ready_q, phi_req_q, y_valid_q, y_last_q, busy_q, done_q;
   logic                    x_ready_d, phi_req_d, y_valid_d, y_last_d, busy_d, done_d;
   logic signed [ACC_W-1:0] y_data_q, y_data_d;

   // Gather the accumulators addressed by the current pass.
   always_comb begin
      for (int l = 0; l < int'(LANES); l++) begin
         acc_rd[l] = y_q[IW'(int'(pass_q) * int'(LANES) + l)];
      end
   end

   cs_acc_bank #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) u_bank (
      .x_reg   (x_reg_q),
      .phi     (bus.phi_in),
      .acc_in  (acc_rd),
      .acc_out (acc_wr)
   );

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      rd_d    = rd_q;
      x_load  = 1'b0;
      acc_we  = 1'b0;
      y_clr   = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         LOAD: begin
            if (bus.x_valid) begin
               x_load  = 1'b1;
               pass_d  = '0;
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            acc_we = 1'b1;
            pass_d = pass_q + PW'(1);
            if (pass_q == PW'(P - 1)) begin
               pass_d = '0;
               if (cnt_q == CW'(N - 1)) begin
                  rd_d    = '0;
                  state_d = DRAIN;
               end else begin
                  cnt_d   = cnt_q + CW'(1);
                  state_d = LOAD;
               end
            end
         end
         DRAIN: begin
            if (bus.y_ready) begin
               y_clr = 1'b1;
               rd_d  = rd_q + IW'(1);
               if (rd_q == IW'(M - 1)) begin
                  rd_d    = '0;
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  state_d = LOAD;
               end
            end
         end
         default: state_d = LOAD;
      endcase

      if (abort) begin
         state_d = LOAD;
         cnt_d   = '0;
         pass_d  = '0;
         rd_d    = '0;
         x_load  = 1'b0;
         acc_we  = 1'b0;
         y_clr   = 1'b0;
         done_d  = 1'b0;
      end

      x_ready_d = (state_d == LOAD);
      phi_req_d = (state_d == COMPUTE);
      y_valid_d = (state_d == DRAIN);
      y_last_d  = y_valid_d && (rd_d == IW'(M - 1));
      busy_d    = (state_d != LOAD) || (cnt_d != '0);
      y_data_d  = '0;
      if (state_d == DRAIN) begin
         // With a single pass, y[0] is still being written when DRAIN is entered.
         y_data_d = (state_q == COMPUTE && P == 1) ? acc_wr[0] : y_q[rd_d];
      end
   end

   // State, counters, sample latch and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= LOAD;
         cnt_q     <= '0;
         pass_q    <= '0;
         rd_q      <= '0;
         x_reg_q   <= '0;
         x_ready_q <= 1'b1;
         phi_req_q <= 1'b0;
         y_valid_q <= 1'b0;
         y_last_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         y_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pass_q    <= pass_d;
         rd_q      <= rd_d;
         if (x_load) x_reg_q <= bus.x_data;
         x_ready_q <= x_ready_d;
         phi_req_q <= phi_req_d;
         y_valid_q <= y_valid_d;
         y_last_q  <= y_last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         y_data_q  <= y_data_d;
      end
   end

   // Accumulator array: lane writes in COMPUTE, clear-on-read in DRAIN, wipe on reset/abort.
   always_ff @(posedge clk) begin
      if (reset || abort) begin
         for (int i = 0; i < int'(M); i++) y_q[i] <= '0;
      end else begin
         if (acc_we) begin
            for (int l = 0; l < int'(LANES); l++) begin
               y_q[IW'(int'(pass_q) * int'(LANES) + l)] <= acc_wr[l];
            end
         end
         if (y_clr) y_q[rd_q] <= '0;
      end
   end

   assign bus.x_ready = x_ready_q;
   assign bus.phi_req = phi_req_q;
   assign bus.y_valid = y_valid_q;
   assign bus.y_last  = y_last_q;
   assign bus.y_data  = y_data_q;
   assign bus.y_idx   = rd_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule
